// File: rtl/ccip_cfg_pkg.sv
// Platform CCI-P limits shared by the request-flow regulators.
// Indexed by virtual channel.
package ccip_cfg_pkg;

  localparam int VC_DEFAULT = 0;
  localparam int NUM_VC = 4;

  localparam int C0_MAX_BW_ACTIVE_LINES[NUM_VC] = '{256, 128, 128, 256};
  localparam int C1_MAX_BW_ACTIVE_LINES[NUM_VC] = '{128, 64, 64, 128};

endpackage

// File: rtl/ccip_throttle_pkg.sv
// Shared types and helpers for CCI-P line-accounting throttles.
// Decodes request lengths into line counts.
package ccip_throttle_pkg;

  typedef logic [1:0] t_ccip_clLen;

  localparam int MAX_LINES_PER_REQ = 4;

  typedef struct packed {
    logic [2:0] lines;
    logic       illegal;
  } cl_lines_t;

  typedef enum logic {
    OPEN,
    THROTTLED
  } thr_state_e;

  // clLen 2 is reserved; charge it the worst case so the count stays safe
  function automatic cl_lines_t cl_len_to_lines(input t_ccip_clLen len);
    cl_lines_t r;
    r.illegal = 1'b0;
    case (len)
      2'd0: r.lines = 3'd1;
      2'd1: r.lines = 3'd2;
      2'd3: r.lines = 3'd4;
      default: begin
        r.lines   = 3'(MAX_LINES_PER_REQ);
        r.illegal = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ccip_c0_active_lines_throttle_if.sv
// Channel-0 request/response/almost-full bundle between AFU, throttle and FIU.
// The master side drives requests and FIU responses.
interface ccip_c0_active_lines_throttle_if;
  import ccip_throttle_pkg::*;

  logic        afu_c0_req_valid;
  t_ccip_clLen afu_c0_req_cl_len;
  logic        fiu_c0_almost_full;
  logic        afu_c0_almost_full;
  logic        fiu_c0_rsp_valid;
  logic        fiu_c0_rsp_is_rdline;
  logic        fiu_c0_rsp_format;
  logic [1:0]  fiu_c0_rsp_cl_num;

  modport master (
    output afu_c0_req_valid,
    output afu_c0_req_cl_len,
    output fiu_c0_almost_full,
    output fiu_c0_rsp_valid,
    output fiu_c0_rsp_is_rdline,
    output fiu_c0_rsp_format,
    output fiu_c0_rsp_cl_num,
    input  afu_c0_almost_full
  );

  modport slave (
    input  afu_c0_req_valid,
    input  afu_c0_req_cl_len,
    input  fiu_c0_almost_full,
    input  fiu_c0_rsp_valid,
    input  fiu_c0_rsp_is_rdline,
    input  fiu_c0_rsp_format,
    input  fiu_c0_rsp_cl_num,
    output afu_c0_almost_full
  );

endinterface

// File: rtl/ccip_sat_updown_counter.sv
// Up/down counter that clamps at zero and saturates at all-ones.
// Also usable for c1 write-line accounting.
module ccip_sat_updown_counter #(
  parameter int W  = 12,
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LW-1:0] inc,
  input  logic [LW-1:0] dec,
  output logic [W-1:0]  count,
  output logic [W-1:0]  next,
  output logic          underflow,
  output logic          overflow
);

  logic [W+1:0] sum;

  // Two guard bits: top bit is the borrow, next is the carry
  always_comb begin
    sum = {2'b00, count}
        + {{(W+2-LW){1'b0}}, inc}
        - {{(W+2-LW){1'b0}}, dec};
    underflow = sum[W+1];
    overflow  = !sum[W+1] && sum[W];
    next      = sum[W-1:0];
    if (underflow) next = '0;
    else if (overflow) next = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= next;
  end

endmodule

// File: rtl/ccip_c0_active_lines_throttle.sv
// Channel-0 read throttle: tracks lines in flight and synthesizes
// an almost-full toward the AFU near the max-bandwidth line limit.
module ccip_c0_active_lines_throttle
  import ccip_throttle_pkg::*;
#(
  parameter int MAX_ACTIVE_LINES =
    ccip_cfg_pkg::C0_MAX_BW_ACTIVE_LINES[ccip_cfg_pkg::VC_DEFAULT],
  parameter int ALM_FULL_SLACK = 8,
  parameter int CNT_W = 12,
  parameter int STAT_W = 32
) (
  input  logic                  pClk,
  input  logic                  pck_cp2af_softReset,
  ccip_c0_active_lines_throttle_if.slave bus,
  output logic [CNT_W-1:0]      active_lines,
  output logic [STAT_W-1:0]     stat_throttle_cycles,
  output logic                  error_flag
);

  localparam int THRESH = MAX_ACTIVE_LINES - MAX_LINES_PER_REQ * ALM_FULL_SLACK;
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

  if (THRESH <= 0 || MAX_ACTIVE_LINES >= (1 << CNT_W)) begin : g_bad_cfg
    $error("ccip_c0_active_lines_throttle: bad MAX_ACTIVE_LINES/ALM_FULL_SLACK/CNT_W");
  end

  cl_lines_t        req_dec;
  logic [2:0]       req_lines;
  logic [2:0]       rsp_lines;
  logic             req_illegal;
  logic [CNT_W-1:0] next;
  logic             underflow;
  logic             overflow;
  thr_state_e       nxt_st;
  logic             fiu_af_q;

  always_comb begin
    req_dec     = cl_len_to_lines(bus.afu_c0_req_cl_len);
    req_lines   = bus.afu_c0_req_valid ? req_dec.lines : 3'd0;
    req_illegal = bus.afu_c0_req_valid && req_dec.illegal;
    rsp_lines   = 3'd0;
    if (bus.fiu_c0_rsp_valid && bus.fiu_c0_rsp_is_rdline)
      rsp_lines = bus.fiu_c0_rsp_format
                ? {1'b0, bus.fiu_c0_rsp_cl_num} + 3'd1
                : 3'd1;
    nxt_st = (next >= THRESH_V) ? THROTTLED : OPEN;
  end

  ccip_sat_updown_counter #(
    .W  (CNT_W),
    .LW (3)
  ) u_cnt (
    .clk       (pClk),
    .rst       (pck_cp2af_softReset),
    .inc       (req_lines),
    .dec       (rsp_lines),
    .count     (active_lines),
    .next      (next),
    .underflow (underflow),
    .overflow  (overflow)
  );

  // Almost-full is held high through reset so the AFU cannot
  // issue before the count is known to be clean
  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      bus.afu_c0_almost_full <= 1'b1;
      fiu_af_q               <= 1'b0;
      stat_throttle_cycles   <= '0;
      error_flag             <= 1'b0;
    end else begin
      bus.afu_c0_almost_full <= bus.fiu_c0_almost_full
                              | (nxt_st == THROTTLED);
      fiu_af_q <= bus.fiu_c0_almost_full;
      if (bus.afu_c0_almost_full && !fiu_af_q
          && stat_throttle_cycles != '1)
        stat_throttle_cycles <= stat_throttle_cycles + 1'b1;
      if (req_illegal || underflow || overflow)
        error_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccip_c0_active_lines_throttle.sv
// Directed self-checking bench for the channel-0 active-lines throttle.
// Inputs change 1 time unit after posedge; outputs are checked there too.
module tb_ccip_c0_active_lines_throttle;
  import ccip_throttle_pkg::*;

  logic        clk;
  logic        rst;
  logic [11:0] active_lines;
  logic [31:0] stat;
  logic        error_flag;
  int          checks;
  int          errors;

  ccip_c0_active_lines_throttle_if bus();

  ccip_c0_active_lines_throttle dut (
    .pClk                 (clk),
    .pck_cp2af_softReset  (rst),
    .bus                  (bus.slave),
    .active_lines         (active_lines),
    .stat_throttle_cycles (stat),
    .error_flag           (error_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.afu_c0_req_valid     = 1'b0;
    bus.afu_c0_req_cl_len    = 2'd0;
    bus.fiu_c0_almost_full   = 1'b0;
    bus.fiu_c0_rsp_valid     = 1'b0;
    bus.fiu_c0_rsp_is_rdline = 1'b0;
    bus.fiu_c0_rsp_format    = 1'b0;
    bus.fiu_c0_rsp_cl_num    = 2'd0;
  endtask

  task automatic rsp(input logic rd, input logic fmt, input logic [1:0] num);
    bus.fiu_c0_rsp_valid     = 1'b1;
    bus.fiu_c0_rsp_is_rdline = rd;
    bus.fiu_c0_rsp_format    = fmt;
    bus.fiu_c0_rsp_cl_num    = num;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    chk("rst_af", 32'(bus.afu_c0_almost_full), 1);
    chk("rst_cnt", 32'(active_lines), 0);
    chk("rst_stat", stat, 0);

    // reset release: one cycle of almost-full, then open
    rst = 1'b0;
    chk("rel_af_hold", 32'(bus.afu_c0_almost_full), 1);
    tick();
    chk("rel_af_drop", 32'(bus.afu_c0_almost_full), 0);
    chk("rel_cnt", 32'(active_lines), 0);
    chk("rel_err", 32'(error_flag), 0);
    chk("rel_stat", stat, 1);

    // 56 four-line requests reach threshold 224
    bus.afu_c0_req_valid  = 1'b1;
    bus.afu_c0_req_cl_len = 2'd3;
    for (int i = 0; i < 55; i++) tick();
    chk("fill55_cnt", 32'(active_lines), 220);
    chk("fill55_af", 32'(bus.afu_c0_almost_full), 0);
    tick();
    idle_inputs();
    chk("fill56_cnt", 32'(active_lines), 224);
    chk("fill56_af", 32'(bus.afu_c0_almost_full), 1);
    chk("fill56_stat", stat, 1);
    repeat (3) tick();
    chk("thr_stat", stat, 4);

    // four unpacked rdline responses from 224
    rsp(1'b1, 1'b0, 2'd0);
    tick();
    chk("drain1_cnt", 32'(active_lines), 223);
    chk("drain1_af", 32'(bus.afu_c0_almost_full), 0);
    repeat (3) tick();
    chk("drain4_cnt", 32'(active_lines), 220);
    chk("drain4_stat", stat, 5);
    rsp(1'b0, 1'b1, 2'd3);
    tick();
    idle_inputs();
    chk("nonrd_cnt", 32'(active_lines), 220);

    // drain to 10: 52 packed x4, then 2 single
    rsp(1'b1, 1'b1, 2'd3);
    for (int i = 0; i < 52; i++) tick();
    rsp(1'b1, 1'b0, 2'd0);
    repeat (2) tick();
    idle_inputs();
    chk("at10_cnt", 32'(active_lines), 10);

    // simultaneous +2 request and -4 packed response
    bus.afu_c0_req_valid  = 1'b1;
    bus.afu_c0_req_cl_len = 2'd1;
    rsp(1'b1, 1'b1, 2'd3);
    tick();
    idle_inputs();
    chk("net_cnt", 32'(active_lines), 8);
    chk("net_err", 32'(error_flag), 0);

    rsp(1'b1, 1'b1, 2'd3);
    repeat (2) tick();
    idle_inputs();
    chk("empty_cnt", 32'(active_lines), 0);

    // FIU almost-full passes through one cycle late, not counted
    bus.fiu_c0_almost_full = 1'b1;
    chk("fiu_pre_af", 32'(bus.afu_c0_almost_full), 0);
    tick();
    chk("fiu_af", 32'(bus.afu_c0_almost_full), 1);
    tick();
    bus.fiu_c0_almost_full = 1'b0;
    tick();
    chk("fiu_af_drop", 32'(bus.afu_c0_almost_full), 0);
    tick();
    chk("fiu_stat", stat, 5);

    // underflow clamps and sticks
    rsp(1'b1, 1'b0, 2'd0);
    tick();
    idle_inputs();
    chk("uf_cnt", 32'(active_lines), 0);
    chk("uf_err", 32'(error_flag), 1);
    repeat (3) tick();
    chk("uf_sticky", 32'(error_flag), 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_err", 32'(error_flag), 0);
    chk("rst2_cnt", 32'(active_lines), 0);

    // illegal clLen counts as 4 lines
    bus.afu_c0_req_valid  = 1'b1;
    bus.afu_c0_req_cl_len = 2'd2;
    tick();
    idle_inputs();
    chk("ill_cnt", 32'(active_lines), 4);
    chk("ill_err", 32'(error_flag), 1);

    // saturation at 4095
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.afu_c0_req_valid  = 1'b1;
    bus.afu_c0_req_cl_len = 2'd3;
    for (int i = 0; i < 1023; i++) tick();
    chk("sat_pre_cnt", 32'(active_lines), 4092);
    chk("sat_pre_err", 32'(error_flag), 0);
    tick();
    idle_inputs();
    chk("sat_cnt", 32'(active_lines), 4095);
    chk("sat_err", 32'(error_flag), 1);
    chk("sat_af", 32'(bus.afu_c0_almost_full), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccip_c0_active_lines_throttle.md
Name: ccip_c0_active_lines_throttle

Overview:
- Channel-0 read-request flow regulator, placed between the AFU and the FIU-facing CCI-P edge registers.
- Counts cache lines in flight: lines requested and not yet returned.
- Raises a synthesized almost-full toward the AFU when the count nears the platform's recommended maximum-bandwidth line limit, with limits taken from ccip_cfg_pkg.
- Purpose: prevent over-subscription that adds latency without adding bandwidth.

Parameters:
- MAX_ACTIVE_LINES, default 256: throttle ceiling. Instantiated as ccip_cfg_pkg::C0_MAX_BW_ACTIVE_LINES[ccip_cfg_pkg::VC_DEFAULT].
- ALM_FULL_SLACK, default 8: requests the AFU may still issue after almost-full asserts (CCI-P rule).
- CNT_W, default 12: width of the active-line counter.
- STAT_W, default 32: width of the throttle-cycle statistic.

Ports:
- pClk  in  1  clock
- pck_cp2af_softReset  in  1  synchronous active-high reset
- afu_c0_req_valid  in  1  AFU issues a c0 read request this cycle
- afu_c0_req_cl_len  in  2  t_ccip_clLen of that request
- fiu_c0_almost_full  in  1  FIU c0TxAlmFull
- afu_c0_almost_full  out  1  almost-full presented to AFU (registered)
- fiu_c0_rsp_valid  in  1  c0 response valid
- fiu_c0_rsp_is_rdline  in  1  response type is a read line (not MMIO/umsg)
- fiu_c0_rsp_format  in  1  packed multi-line response
- fiu_c0_rsp_cl_num  in  2  clNum of response
- active_lines  out  CNT_W  current lines in flight (registered)
- stat_throttle_cycles  out  STAT_W  cycles throttled by this block only
- error_flag  out  1  sticky: illegal clLen, counter underflow, or counter saturation

Behaviour:
- Reset: active_lines=0, stat_throttle_cycles=0, error_flag=0. afu_c0_almost_full=1 during reset and for the first cycle after reset deasserts.
- Request lines, counted when afu_c0_req_valid=1: clLen 0→1, 1→2, 3→4. clLen 2 is illegal; count it as 4 and set error_flag.
- Response lines, counted when fiu_c0_rsp_valid & fiu_c0_rsp_is_rdline: format=1 → cl_num+1; format=0 → 1. Non-rdline responses are ignored.
- Next count: next = active_lines + req_lines − rsp_lines, computed at CNT_W+2 bits. A simultaneous request and response in one cycle nets to a single update.
  - next < 0: clamp to 0 and set error_flag.
  - next > 2^CNT_W−1: saturate and set error_flag.
- Throttle threshold: THRESH = MAX_ACTIVE_LINES − 4*ALM_FULL_SLACK, so worst-case slack requests each carry 4 lines.
  - Elaboration-time $error if THRESH ≤ 0 or MAX_ACTIVE_LINES ≥ 2^CNT_W.
- afu_c0_almost_full is updated every cycle: afu_c0_almost_full <= fiu_c0_almost_full | (next ≥ THRESH). This adds one cycle of latency relative to the FIU signal; ALM_FULL_SLACK covers it.
- Requests issued while almost-full is asserted are still counted. The block never drops or blocks requests; the AFU owns compliance.
- stat_throttle_cycles increments when afu_c0_almost_full=1 and the registered fiu_c0_almost_full=0. It saturates at all-ones.
- State: a two-state view, OPEN (count < THRESH) and THROTTLED (count ≥ THRESH), derived from the count.
  - OPEN→THROTTLED when next ≥ THRESH.
  - THROTTLED→OPEN when next < THRESH. There is no hysteresis.
- Reset mid-operation: all state clears immediately. Responses arriving afterwards for pre-reset requests hit underflow, clamp to 0 and set error_flag. Software must quiesce c0 before asserting softReset.

Decomposition:
- Shared package ccip_throttle_pkg holds:
  - function cl_len_to_lines(t_ccip_clLen) returning 3 bits, plus an illegal-length indication;
  - localparam for the maximum lines per request (4).
- Limits come from ccip_cfg_pkg; nothing is duplicated.
- One sub-module: ccip_sat_updown_counter (parameter W; inputs inc, dec; outputs count, underflow, overflow). It implements the clamp/saturate arithmetic and is reusable for c1 write-line accounting.

Test Plan (defaults: MAX_ACTIVE_LINES=256, ALM_FULL_SLACK=8, THRESH=224):
1. Reset release → afu_c0_almost_full=1 for one cycle, then 0; active_lines=0, error_flag=0.
2. 56 requests of clLen=3, no responses → active_lines=224. afu_c0_almost_full rises in the cycle after the 56th request. stat_throttle_cycles then increments once per cycle with fiu_c0_almost_full=0.
3. Same cycle: clLen=1 request plus packed response with cl_num=3 at active_lines=10 → active_lines=8.
4. 224 lines active; four unpacked rdline responses → active_lines=220, and almost-full drops the following cycle. A non-rdline response leaves the count unchanged.
5. fiu_c0_almost_full=1 at active_lines=0 → afu_c0_almost_full=1 one cycle later; stat_throttle_cycles unchanged.
6. Error cases:
   - Response at active_lines=0 → active_lines stays 0, error_flag=1 and sticky until reset.
   - clLen=2 request → +4 lines, error_flag=1.
